ltl_symbol_streamer: RTL and testbench
======================================

# ltl_symbol_streamer

Feeds the cluster LTL monitors with their input stream: accepts 8-bit trace symbols from core event logic over a valid/ready handshake, buffers them, and drives the monitor-side `symbols`/`run`/`reset` triple one symbol per cycle. It sits between the core trace tap and each monitor cluster top, and owns the monitor reset sequencing so a monitor never sees a partial trace.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `MON_RST_CYCLES`, 2, cycles `mon_reset` is held after `start`; at least 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a trace session.
- `stop`  in  1  single-cycle pulse that ends the session after draining.
- `ev_valid`  in  1  an event symbol is offered.
- `ev_symbol`  in  8  event symbol.
- `ev_ready`  out  1  the symbol is accepted on an edge where `ev_valid` and `ev_ready` are both 1.
- `symbols`  out  8  symbol to the monitor; registered.
- `run`  out  1  `symbols` is valid this cycle; registered.
- `mon_reset`  out  1  reset to the monitor; registered.
- `busy`  out  1  the state is not IDLE.
- `stall_cnt`  out  16  starvation count (see Configuration).

## Operation
- Reset values:
  - state IDLE, FIFO empty.
  - `symbols`=8'h00, `run`=0, `mon_reset`=1, `busy`=0, `ev_ready`=0, `stall_cnt`=0.
- FSM states: IDLE, MON_RST, STREAM, DRAIN.
- **IDLE**
  - `mon_reset`=1, `ev_ready`=0.
  - `start` → MON_RST and loads the reset counter with MON_RST_CYCLES−1.
  - `stop` is ignored.
- **MON_RST**
  - `mon_reset`=1, `run`=0, `ev_ready`=!full, so events are buffered during the monitor reset.
  - When the counter reaches 0 → STREAM.
  - `stop` → IDLE and clears the FIFO.
- **STREAM**
  - `mon_reset`=0, `ev_ready`=!full.
  - FIFO non-empty: pop the head into `symbols` and set `run`=1.
  - FIFO empty: `run`=0 and `symbols` holds its last value.
  - `start` is ignored.
  - `stop` → DRAIN.
- **DRAIN**
  - `ev_ready`=0; popping continues as in STREAM.
  - Empty at the edge → IDLE, with `run`=0 and `mon_reset`=1 on the following cycle.
- Full: `ev_ready`=0 even when a pop occurs in the same cycle; there is no push-on-pop when full.
- Empty: there is no bypass path; a push into an empty FIFO is popped on the next edge.
- `stop` and `start` in the same cycle: `stop` wins in MON_RST and STREAM; `start` wins in IDLE.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the low bits are equal.
- Symbol order is preserved exactly. No symbol is dropped or duplicated.

## Timing
- Handshake acceptance at edge k: the symbol appears on `symbols` with `run`=1 after edge k+1 at the earliest (1-cycle latency).
- Sustained throughput: 1 symbol per cycle.
- The `start` edge is followed by exactly MON_RST_CYCLES cycles of `mon_reset`=1 (already 1 from IDLE), then the first possible `run`=1 cycle.
- `reset` asserted mid-session: every output takes its reset value immediately (asynchronously) and the FIFO contents are lost.

## Configuration
- Macro: `LTL_STREAM_STALL_CNT_EN`.
- Defined:
  - `stall_cnt` increments, saturating at 16'hFFFF, on every STREAM cycle where the FIFO is empty.
  - It clears on `start`.
- Undefined: `stall_cnt` is tied to 0 and no counter logic is built.

## Structure
- Package `ltl_stream_pkg` holds:
  - the state enum `stream_state_e`;
  - `SYM_W`=8;
  - the reset value of `symbols`, `IDLE_SYM`=8'h00.
- Sub-module `ltl_sym_fifo`: a synchronous FIFO with DEPTH and width parameters, push/pop/full/empty/clear ports, and the same clock and asynchronous reset.

## Test plan
- Reset: `reset` pulse → `mon_reset`=1, `run`=0, `symbols`=8'h00, `ev_ready`=0.
- Start with MON_RST_CYCLES=2: `start` at edge 0 → `mon_reset`=1 through cycle 2, then 0. `ev_ready`=1 during MON_RST.
- Ordered stream: push 8'hA1, 8'hB2, 8'hC3 on consecutive edges in STREAM → `symbols` shows A1, B2, C3 with `run`=1 on the three edges after each push, then `run`=0.
- Full: hold `ev_valid` for 12 cycles while the monitor is stalled by `stop` suppression in MON_RST with MON_RST_CYCLES=16 → exactly DEPTH=8 accepted and `ev_ready`=0 afterwards. In STREAM, all 8 emerge in order.
- Drain: `stop` with 3 symbols queued → 3 more `run`=1 cycles, then IDLE, `mon_reset`=1, `busy`=0.
- Stall counter (with `LTL_STREAM_STALL_CNT_EN`): 5 empty STREAM cycles → `stall_cnt`=5. Without the macro → 0.

Source files
------------

// File: rtl/ltl_symbol_streamer_pkg.sv
// rtl/ltl_symbol_streamer_pkg.sv - shared types and constants for the LTL symbol streamer
package ltl_stream_pkg;

    localparam int SYM_W = 8;
    localparam logic [SYM_W-1:0] IDLE_SYM = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MON_RST = 2'd1,
        STREAM  = 2'd2,
        DRAIN   = 2'd3
    } stream_state_e;

endpackage

// File: rtl/ltl_symbol_streamer_if.sv
// rtl/ltl_symbol_streamer_if.sv - event-side handshake and monitor-side symbol bundle
interface ltl_symbol_streamer_if;
    import ltl_stream_pkg::*;

    logic             ev_valid;
    logic [SYM_W-1:0] ev_symbol;
    logic             ev_ready;
    logic [SYM_W-1:0] symbols;
    logic             run;
    logic             mon_reset;

    modport master (
        output ev_valid, ev_symbol,
        input  ev_ready, symbols, run, mon_reset
    );

    modport slave (
        input  ev_valid, ev_symbol,
        output ev_ready, symbols, run, mon_reset
    );

endinterface

// File: rtl/ltl_symbol_streamer_fifo.sv
// rtl/ltl_symbol_streamer_fifo.sv - synchronous symbol FIFO with wrap-bit pointers and clear
module ltl_sym_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata   = mem_q[rptr_q[AW-1:0]];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ltl_symbol_streamer.sv
// rtl/ltl_symbol_streamer.sv - buffers trace symbols and sequences monitor reset/run
// Optional starvation counter enabled by LTL_STREAM_STALL_CNT_EN.
module ltl_symbol_streamer
    import ltl_stream_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int MON_RST_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    ltl_symbol_streamer_if.slave   sif,
    output logic                   busy,
    output logic [15:0]            stall_cnt
);

    localparam int CNT_W = (MON_RST_CYCLES > 1) ? $clog2(MON_RST_CYCLES) : 1;

    stream_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SYM_W-1:0] symbols_q;
    logic             run_q;
    logic             mon_reset_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             clear;
    logic [SYM_W-1:0] head;

    assign sif.ev_ready = ((state_q == MON_RST) || (state_q == STREAM)) && !full;
    assign push         = sif.ev_valid && sif.ev_ready;
    // The last MON_RST edge already pops, so the first run cycle follows mon_reset directly.
    assign pop          = !empty && ((state_q == STREAM) || (state_q == DRAIN) ||
                                     ((state_q == MON_RST) && (cnt_q == '0) && !stop));
    assign clear        = (state_q == MON_RST) && stop;

    ltl_sym_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SYM_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (sif.ev_symbol),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            symbols_q   <= IDLE_SYM;
            run_q       <= 1'b0;
            mon_reset_q <= 1'b1;
        end else begin
            run_q <= pop;
            if (pop) symbols_q <= head;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= MON_RST;
                        cnt_q   <= CNT_W'(MON_RST_CYCLES - 1);
                    end
                end
                MON_RST: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q     <= STREAM;
                        mon_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                STREAM: begin
                    if (stop) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (empty) begin
                        state_q     <= IDLE;
                        mon_reset_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign sif.symbols   = symbols_q;
    assign sif.run       = run_q;
    assign sif.mon_reset = mon_reset_q;
    assign busy          = (state_q != IDLE);

`ifdef LTL_STREAM_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == STREAM) && empty && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ltl_symbol_streamer.sv
// tb/tb_ltl_symbol_streamer.sv - scoreboard bench for ltl_symbol_streamer
module tb_ltl_symbol_streamer;

    localparam int DEPTH = 8;
    localparam int MRC   = 16;
`ifdef LTL_STREAM_STALL_CNT_EN
    localparam int STALL_EXP = 5;
`else
    localparam int STALL_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        busy;
    logic [15:0] stall_cnt;

    ltl_symbol_streamer_if sif();

    ltl_symbol_streamer #(
        .DEPTH          (DEPTH),
        .MON_RST_CYCLES (MRC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .sif       (sif),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted symbols queue up in order; every run cycle must present the oldest one.
    always @(negedge clk) begin
        if (!reset) begin
            if (sif.run) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_run: symbols=%0h with run=1, expected no pending symbol", sif.symbols);
                end else begin
                    check("symbol_order", 32'(sif.symbols), 32'(exp_q.pop_front()));
                end
            end
            if (sif.ev_valid && sif.ev_ready) exp_q.push_back(sif.ev_symbol);
        end
    end

    // Starts a session, offers nval consecutive symbols from base, returns at the first mon_reset=0 sample.
    task automatic start_sess(input int nval, input logic [7:0] base, output int acc, output int mr,
                              output logic ready0, output logic ready_end);
        logic took;
        @(posedge clk); #1;
        start = 1'b1;
        sif.ev_valid  = (nval > 0);
        sif.ev_symbol = base;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0; mr = 0; ready0 = 1'b0; ready_end = 1'b1;
        for (int c = 0; c < 4*MRC; c++) begin
            @(negedge clk);
            if (!sif.mon_reset) break;
            took = sif.ev_valid && sif.ev_ready;
            if (c == 0) ready0 = sif.ev_ready;
            if (c == nval - 1) ready_end = sif.ev_ready;
            if (took) acc++;
            mr++;
            @(posedge clk); #1;
            if (took) sif.ev_symbol = sif.ev_symbol + 8'd1;
            if (c == nval - 1) sif.ev_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(output int nrun);
        nrun = 0;
        for (int c = 0; c < DEPTH + 4; c++) begin
            @(negedge clk);
            if (!busy) break;
            if (sif.run) nrun++;
        end
    endtask

    initial begin
        int acc, mr, nrun;
        logic r0, rend;
        logic [5:0] pat;
        logic [7:0] tbl [3];
        tbl = '{8'hA1, 8'hB2, 8'hC3};

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        sif.ev_valid = 1'b0; sif.ev_symbol = 8'h00;
        @(negedge clk);
        check("rst_mon_reset", 32'(sif.mon_reset), 1);
        check("rst_run",       32'(sif.run), 0);
        check("rst_symbols",   32'(sif.symbols), 0);
        check("rst_ev_ready",  32'(sif.ev_ready), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        reset = 1'b0;

        // Fill during the monitor reset: exactly DEPTH accepted out of 12 offered.
        start_sess(12, 8'h10, acc, mr, r0, rend);
        check("mon_rst_cycles",     mr, MRC);
        check("ready_in_mon_rst",   32'(r0), 1);
        check("full_accepted",      acc, DEPTH);
        check("ready_when_full",    32'(rend), 0);
        check("run_at_stream_entry", 32'(sif.run), 1);
        check("busy_in_stream",     32'(busy), 1);
        repeat (DEPTH + 2) @(negedge clk);
        check("full_all_emerged",   exp_q.size(), 0);

        // Ordered stream with one-cycle latency.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                sif.ev_valid = 1'b1; sif.ev_symbol = tbl[i];
            end else begin
                sif.ev_valid = 1'b0;
            end
            @(negedge clk);
            pat[i] = sif.run;
        end
        check("run_pattern", 32'(pat), 32'(6'b011100));

        // Random traffic in STREAM, then stop and drain.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            sif.ev_valid  = 1'($urandom_range(0, 1));
            sif.ev_symbol = 8'($urandom);
        end
        @(posedge clk); #1;
        sif.ev_valid = 1'b0; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_idle(nrun);
        check("random_idle",      32'(busy), 0);
        check("random_all_out",   exp_q.size(), 0);

        // Drain with three symbols still queued at the stop edge.
        start_sess(4, 8'h40, acc, mr, r0, rend);
        check("drain_accepted", acc, 4);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_idle(nrun);
        check("drain_run_cycles", nrun, 3);
        check("drain_mon_reset",  32'(sif.mon_reset), 1);
        check("drain_run_off",    32'(sif.run), 0);
        check("drain_busy",       32'(busy), 0);

        // Abort in MON_RST discards buffered symbols.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; sif.ev_valid = 1'b1; sif.ev_symbol = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        sif.ev_valid = 1'b0; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        check("abort_busy",      32'(busy), 0);
        check("abort_mon_reset", 32'(sif.mon_reset), 1);
        exp_q.delete();

        // Fresh session with no traffic: starvation counting.
        start_sess(0, 8'h00, acc, mr, r0, rend);
        check("restart_mon_rst_cycles", mr, MRC);
        check("stall_cleared",          32'(stall_cnt), 0);
        repeat (5) @(negedge clk);
        check("stall_count",            32'(stall_cnt), STALL_EXP);

        // Asynchronous reset mid-session with a symbol in flight.
        @(posedge clk); #1;
        sif.ev_valid = 1'b1; sif.ev_symbol = 8'h77;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("arst_mon_reset", 32'(sif.mon_reset), 1);
        check("arst_run",       32'(sif.run), 0);
        check("arst_symbols",   32'(sif.symbols), 0);
        check("arst_busy",      32'(busy), 0);
        check("arst_ev_ready",  32'(sif.ev_ready), 0);
        check("arst_stall_cnt", 32'(stall_cnt), 0);
        sif.ev_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        start_sess(0, 8'h00, acc, mr, r0, rend);
        check("post_arst_mon_rst_cycles", mr, MRC);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
